// File: rtl/hamming1511_pkg.sv
// Shared Hamming(15,11) widths, code-position tables and bit-placement helpers.
// Code bit i sits at 1-based position i+1; parity occupies the power-of-two positions.
package hamming1511_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 15;
    localparam int SYN_W  = 4;

    // Zero-based codeword bit indices of the parity and data bits.
    localparam int PARITY_POS [SYN_W]  = '{0, 1, 3, 7};
    localparam int DATA_POS   [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYN_W-1:0]  syn_t;

    function automatic data_t extract_data(input code_t cw);
        data_t d;
        d = '0;
        for (int j = 0; j < DATA_W; j++) begin
            d[j] = cw[DATA_POS[j]];
        end
        return d;
    endfunction

    function automatic code_t encode(input data_t d);
        code_t cw;
        logic  p;
        cw = '0;
        for (int j = 0; j < DATA_W; j++) begin
            cw[DATA_POS[j]] = d[j];
        end
        // Parity slots are still zero here, so each parity covers only data bits.
        for (int k = 0; k < SYN_W; k++) begin
            p = 1'b0;
            for (int i = 0; i < CODE_W; i++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    p = p ^ cw[i];
                end
            end
            cw[PARITY_POS[k]] = p;
        end
        return cw;
    endfunction

endpackage

// File: rtl/hamming1511_syndrome.sv
// Combinational Hamming(15,11) syndrome: s[k] is the parity of all code bits whose
// 1-based position has bit k set. Zero latency, no flow control.
module hamming1511_syndrome
    import hamming1511_pkg::*;
(
    input  code_t codeword,
    output syn_t  syndrome
);

    always_comb begin
        syndrome = '0;
        for (int k = 0; k < SYN_W; k++) begin
            for (int i = 0; i < CODE_W; i++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    syndrome[k] = syndrome[k] ^ codeword[i];
                end
            end
        end
    end

endmodule

// File: rtl/hamming1511_decoder.sv
// Hamming(15,11) single-error-correcting decoder, two-stage pipeline (syndrome, correct), 2-cycle latency.
// Valid/ready on both sides, full throughput; a stalled output freezes both stages and drops in_ready.
module hamming1511_decoder
    import hamming1511_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [14:0]       in_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [10:0]       out_data,
    output logic              out_err,
    output logic [3:0]        out_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_words,
    output logic [CNT_W-1:0]  cnt_corr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic  s1_vld;
    code_t s1_cw;
    syn_t  s1_syn;
    syn_t  in_syn;
    logic  s2_vld;
    logic  s2_load;
    logic  in_fire;
    logic  out_fire;
    code_t corr_cw;

    hamming1511_syndrome u_syndrome (
        .codeword (in_codeword),
        .syndrome (in_syn)
    );

    assign out_valid = s2_vld;
    assign out_fire  = s2_vld && out_ready;
    assign s2_load   = !s2_vld || out_ready;
    // Gated by rst_n so the block refuses words while held in reset.
    assign in_ready  = rst_n && (!s1_vld || s2_load);
    assign in_fire   = in_valid && in_ready;

    // A syndrome of s points at 1-based position s, i.e. code bit s-1.
    assign corr_cw = s1_cw ^ ((s1_syn != '0) ? (code_t'(1) << (s1_syn - SYN_W'(1))) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_cw  <= '0;
            s1_syn <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_fire) begin
                s1_cw  <= in_codeword;
                s1_syn <= in_syn;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
            out_pos  <= '0;
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                out_data <= extract_data(corr_cw);
                out_err  <= (s1_syn != '0);
                out_pos  <= s1_syn;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_words <= '0;
            cnt_corr  <= '0;
        end else if (cnt_clr) begin
            cnt_words <= '0;
            cnt_corr  <= '0;
        end else if (out_fire) begin
            if (cnt_words != CNT_MAX) begin
                cnt_words <= cnt_words + CNT_W'(1);
            end
            if (out_err && (cnt_corr != CNT_MAX)) begin
                cnt_corr <= cnt_corr + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming1511_decoder.sv
// Scoreboard bench for hamming1511_decoder: stimulus pushes reference decodes, a monitor pops on output.
// Reference model works on 1-based code positions (syndrome = XOR of positions of set bits).
module tb_hamming1511_decoder;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [14:0]       in_codeword;
    logic              out_valid;
    logic              out_ready;
    logic [10:0]       out_data;
    logic              out_err;
    logic [3:0]        out_pos;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_words;
    logic [CNT_W-1:0]  cnt_corr;

    hamming1511_decoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_codeword (in_codeword),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .out_pos     (out_pos),
        .cnt_clr     (cnt_clr),
        .cnt_words   (cnt_words),
        .cnt_corr    (cnt_corr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] data;
        logic        err;
        logic [3:0]  pos;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        pe;
    exp_t        me;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_deliv = 0;
    int          exp_words = 0;
    int          exp_corr = 0;
    bit          lat_chk = 0;
    bit          rnd_on = 0;
    bit          saw_block = 0;
    bit          prev_stall = 0;
    bit          fire;
    bit          fire_err;
    logic [10:0] prev_data;
    logic        prev_err;
    logic [3:0]  prev_pos;
    logic [10:0] last_data;
    logic        last_err;
    logic [3:0]  last_pos;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] ref_encode(input logic [10:0] d);
        logic [14:0] cw;
        int          j;
        int          syn;
        cw = '0;
        j = 0;
        syn = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                j++;
            end
        end
        for (int p = 1; p <= 15; p++) begin
            if (cw[p-1]) syn = syn ^ p;
        end
        for (int b = 0; b < 4; b++) begin
            if (((syn >> b) & 1) != 0) cw[(1 << b) - 1] = 1'b1;
        end
        return cw;
    endfunction

    function automatic exp_t ref_decode(input logic [14:0] cw);
        exp_t        e;
        logic [14:0] c;
        int          syn;
        int          j;
        syn = 0;
        for (int p = 1; p <= 15; p++) begin
            if (cw[p-1]) syn = syn ^ p;
        end
        c = cw;
        if (syn != 0) c[syn-1] = ~c[syn-1];
        e.data = '0;
        j = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                e.data[j] = c[p-1];
                j++;
            end
        end
        e.err = (syn != 0);
        e.pos = syn[3:0];
        e.cyc = 0;
        e.lat = 0;
        return e;
    endfunction

    // Stimulus side: record the expected response of every accepted word.
    always @(negedge clk) begin
        #1;
        if (rst_n && in_valid && in_ready) begin
            pe     = ref_decode(in_codeword);
            pe.cyc = cyc;
            pe.lat = lat_chk;
            sb.push_back(pe);
        end
    end

    // Monitor: compares outputs, handshake, hold behaviour and counters.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_err", out_err, 0);
            check("rst_out_pos", out_pos, 0);
            check("rst_cnt_words", cnt_words, 0);
            check("rst_cnt_corr", cnt_corr, 0);
            sb.delete();
            exp_words  = 0;
            exp_corr   = 0;
            prev_stall = 0;
        end else begin
            check("in_ready", in_ready, (sb.size() < 2 || out_ready) ? 1 : 0);
            if (!in_ready) saw_block = 1;
            check("cnt_words", cnt_words, exp_words);
            check("cnt_corr", cnt_corr, exp_corr);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_err", out_err, prev_err);
                check("hold_pos", out_pos, prev_pos);
            end
            fire = 0;
            fire_err = 0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_output_sb_size", sb.size(), 1);
                end else begin
                    me = sb[0];
                    check("out_data", out_data, me.data);
                    check("out_err", out_err, me.err);
                    check("out_pos", out_pos, me.pos);
                    if (out_ready) begin
                        fire = 1;
                        fire_err = me.err;
                        if (me.lat && lat_chk) check("latency", cyc - me.cyc, 2);
                        void'(sb.pop_front());
                    end
                end
                if (out_ready) begin
                    n_deliv++;
                    last_data = out_data;
                    last_err  = out_err;
                    last_pos  = out_pos;
                end
            end
            if (cnt_clr) begin
                exp_words = 0;
                exp_corr  = 0;
            end else if (fire) begin
                if (exp_words < CMAX) exp_words++;
                if (fire_err && exp_corr < CMAX) exp_corr++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_err   = out_err;
            prev_pos   = out_pos;
        end
    end

    task automatic send(input logic [14:0] cw);
        bit fired;
        fired = 0;
        in_valid = 1'b1;
        in_codeword = cw;
        for (int t = 0; t < 100 && !fired; t++) begin
            @(negedge clk);
            fired = in_ready && rst_n;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accepted", fired, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_cnt_words", cnt_words, 0);
        check("clr_cnt_corr", cnt_corr, 0);
    endtask

    function automatic logic [14:0] err_word(input logic [10:0] d, input int mode);
        logic [14:0] cw;
        int          b1;
        int          b2;
        cw = ref_encode(d);
        b1 = $urandom_range(0, 14);
        b2 = (b1 + $urandom_range(1, 14)) % 15;
        if (mode >= 1) cw[b1] = ~cw[b1];
        if (mode == 2) cw[b2] = ~cw[b2];
        return cw;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [14:0] sw;
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_codeword = '0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        lat_chk = 1;

        // Clean all-ones word, then the same word with code bit 5 flipped.
        send(15'h7FFF);
        drain();
        check("clean_data", last_data, 11'h7FF);
        check("clean_err", last_err, 0);
        check("clean_pos", last_pos, 0);
        check("clean_cnt_words", cnt_words, 1);
        check("clean_cnt_corr", cnt_corr, 0);
        send(15'h7FDF);
        drain();
        check("single_data", last_data, 11'h7FF);
        check("single_err", last_err, 1);
        check("single_pos", last_pos, 6);
        check("single_cnt_corr", cnt_corr, 1);

        // Every single-bit error on the all-zero codeword, back to back.
        for (int i = 0; i < 15; i++) begin
            sw = '0;
            sw[i] = 1'b1;
            send(sw);
        end
        drain();
        check("sweep_last_pos", last_pos, 15);

        // Eight-word stream with a four-cycle output stall.
        lat_chk = 0;
        saw_block = 0;
        base = n_deliv;
        fork
            begin
                for (int i = 0; i < 8; i++) send(ref_encode(11'($urandom)));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", n_deliv - base, 8);
        check("bp_in_ready_dropped", saw_block, 1);

        // Saturation of the narrow counters, then clear.
        clr_pulse();
        for (int i = 0; i < 20; i++) send(err_word(11'($urandom), 1));
        drain();
        check("sat_cnt_words", cnt_words, CMAX);
        check("sat_cnt_corr", cnt_corr, CMAX);
        clr_pulse();

        // Reset with two words in flight.
        lat_chk = 1;
        send(ref_encode(11'h5A5));
        send(err_word(11'h3C3, 1));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = n_deliv;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_delivery", n_deliv - base, 0);
        check("midrst_cnt_words", cnt_words, 0);

        // Randomised traffic: clean, single and double errors with random stalls and clears.
        lat_chk = 0;
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(err_word(11'($urandom), $urandom_range(0, 2)));
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    cnt_clr = ($urandom_range(0, 19) == 0);
                end
                out_ready = 1'b1;
                cnt_clr = 1'b0;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
